btn_debounce_pulse: RTL

BTN_DEBOUNCE_PULSE -- requirements
Module: btn_debounce_pulse

---
 rtl/btn_debounce_pulse.sv | 131 +++++++++++++
 1 files changed

// File: rtl/btn_debounce_pulse.sv
// Push-button debouncer: 2-flop synchronizer, 4-state stability FSM, registered
// press/release strobes and a 2-bit wrapping count of enabled presses.
module btn_debounce_pulse #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    input  logic       enable,
    output logic       btn_state,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [1:0] press_count
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPressWait,
        StHeld,
        StReleaseWait
    } state_e;

    logic [1:0]      sync_q;
    logic            pressed_s;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            press_evt, release_evt;

    logic            btn_state_q, btn_state_d;
    logic            press_pulse_q, press_pulse_d;
    logic            release_pulse_q, release_pulse_d;
    logic [1:0]      press_count_q, press_count_d;

    // Stages idle high so a released button never looks pressed out of reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    assign pressed_s = ~sync_q[1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_evt   = 1'b0;
        release_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pressed_s) begin
                    state_d = StPressWait;
                    cnt_d   = '0;
                end
            end
            StPressWait: begin
                if (!pressed_s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d   = StHeld;
                    press_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StHeld: begin
                if (!pressed_s) begin
                    state_d = StReleaseWait;
                    cnt_d   = '0;
                end
            end
            StReleaseWait: begin
                if (pressed_s) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d     = StIdle;
                    release_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        endcase
    end

    // Outputs register the next state so btn_state tracks HELD/RELEASE_WAIT exactly.
    always_comb begin
        btn_state_d     = (state_d == StHeld) || (state_d == StReleaseWait);
        press_pulse_d   = press_evt & enable;
        release_pulse_d = release_evt & enable;
        press_count_d   = press_count_q;
        if (press_evt && enable) begin
            press_count_d = press_count_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_state_q     <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            press_count_q   <= 2'b00;
        end else begin
            btn_state_q     <= btn_state_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            press_count_q   <= press_count_d;
        end
    end

    assign btn_state     = btn_state_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign press_count   = press_count_q;

endmodule
